adder_bist_ctrl: RTL

Built-in self-test sequencer for the W-bit ripple-carry adder under test (chain of full_adder cells, possibly with injected faulty cells). On `start` it drives every {CIN, B, A} combination into the adder, one vector per cycle. It compares the returned SUM against an internally computed golden sum through a LAT-deep pipeline, and reports pass/fail, a per-bit fault mask, a saturating mismatch count and the first failing vector. It sits between the test harness and the adder instance, replacing plusarg-driven single-shot stimulus.

---
 rtl/adder_test_pkg.sv | 23 ++
 rtl/bist_compare_pipe.sv | 55 +++++
 rtl/adder_bist_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/adder_test_pkg.sv
// Shared types and helpers for the adder BIST controller and its bench.
// golden_sum is width-generic through a wide operand; callers truncate the result.
package adder_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    localparam int FAIL_CNT_W = 16;
    localparam int GOLD_OP_W  = 32;

    function automatic logic [GOLD_OP_W:0] golden_sum(
        input logic [GOLD_OP_W-1:0] a,
        input logic [GOLD_OP_W-1:0] b,
        input logic                 cin
    );
        return {1'b0, a} + {1'b0, b} + {{GOLD_OP_W{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/bist_compare_pipe.sv
// LAT-deep golden/valid shift register that lines each launched vector up with
// the SUM it produces and flags a mismatch at the last stage.
module bist_compare_pipe
    import adder_test_pkg::*;
#(
    parameter int W   = 8,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic         i_valid,
    input  logic [2*W:0] i_vec,
    input  logic [W:0]   i_sum,
    output logic         o_mismatch,
    output logic [W:0]   o_diff,
    output logic [2*W:0] o_vec,
    output logic         o_any_valid
);

    logic [LAT-1:0] r_valid;
    logic [W:0]     r_gold [LAT];
    logic [2*W:0]   r_vec  [LAT];
    logic [W:0]     w_gold_in;

    assign w_gold_in = (W+1)'(golden_sum(GOLD_OP_W'(i_vec[W-1:0]),
                                         GOLD_OP_W'(i_vec[2*W-1:W]),
                                         i_vec[2*W]));

    always_ff @(posedge clk) begin
        if (i_rst || i_flush) begin
            r_valid <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_gold[i] <= '0;
                r_vec[i]  <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_gold[0]  <= w_gold_in;
            r_vec[0]   <= i_vec;
            for (int i = 1; i < LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_gold[i]  <= r_gold[i-1];
                r_vec[i]   <= r_vec[i-1];
            end
        end
    end

    // Diff is forced to zero when the last stage is empty so callers can OR it blindly.
    assign o_diff      = r_valid[LAT-1] ? (i_sum ^ r_gold[LAT-1]) : '0;
    assign o_mismatch  = |o_diff;
    assign o_vec       = r_vec[LAT-1];
    assign o_any_valid = |r_valid;

endmodule

// File: rtl/adder_bist_ctrl.sv
// Exhaustive BIST sequencer for a W-bit adder: sweeps every {CIN,B,A}, checks SUM
// against a pipelined golden sum and accumulates mask, count and first failure.
module adder_bist_ctrl
    import adder_test_pkg::*;
#(
    parameter int W            = 8,
    parameter int LAT          = 1,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic [W-1:0]          A,
    output logic [W-1:0]          B,
    output logic                  CIN,
    input  logic [W:0]            SUM,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [W:0]            fail_mask,
    output logic [FAIL_CNT_W-1:0] fail_count,
    output logic [2*W:0]          first_fail_vec,
    output logic                  first_fail_valid
);

    localparam int                    VW       = 2*W + 1;
    localparam logic [VW-1:0]         LAST_VEC = '1;
    localparam logic [FAIL_CNT_W-1:0] CNT_MAX  = '1;

    bist_state_e r_state;
    bist_state_e w_state_next;

    logic [VW-1:0]         r_cnt;
    logic [VW-1:0]         w_launch_vec;
    logic                  w_start_ok;
    logic                  w_stop;
    logic                  w_launch;
    logic                  w_mismatch;
    logic                  w_any_valid;
    logic [W:0]            w_diff;
    logic [VW-1:0]         w_cmp_vec;
    logic [W:0]            r_fail_mask;
    logic [FAIL_CNT_W-1:0] r_fail_count;
    logic [VW-1:0]         r_first_vec;
    logic                  r_first_valid;

    assign w_start_ok   = start && !abort && (r_state == ST_IDLE || r_state == ST_DONE);
    // With stop-on-fail the failing edge itself must not launch, otherwise one
    // more vector would be in flight and get counted.
    assign w_stop       = (STOP_ON_FAIL != 0) && w_mismatch;
    assign w_launch     = w_start_ok || (r_state == ST_RUN && !abort && !w_stop);
    assign w_launch_vec = w_start_ok ? '0 : r_cnt + VW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: if (start) w_state_next = ST_RUN;
                ST_RUN:           if (w_stop || w_launch_vec == LAST_VEC) w_state_next = ST_DRAIN;
                ST_DRAIN:         if (!w_any_valid) w_state_next = ST_DONE;
                default:          w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (r_state == ST_RUN) || (r_state == ST_DRAIN);
        done = (r_state == ST_DONE);
        pass = (r_state == ST_DONE) && (r_fail_count == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_launch) begin
            r_cnt <= w_launch_vec;
        end
    end

    assign A   = r_cnt[W-1:0];
    assign B   = r_cnt[2*W-1:W];
    assign CIN = r_cnt[2*W];

    bist_compare_pipe #(
        .W   (W),
        .LAT (LAT)
    ) u_pipe (
        .clk         (clk),
        .i_rst       (rst),
        .i_flush     (abort),
        .i_valid     (w_launch),
        .i_vec       (w_launch_vec),
        .i_sum       (SUM),
        .o_mismatch  (w_mismatch),
        .o_diff      (w_diff),
        .o_vec       (w_cmp_vec),
        .o_any_valid (w_any_valid)
    );

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_fail_mask   <= '0;
            r_fail_count  <= '0;
            r_first_vec   <= '0;
            r_first_valid <= 1'b0;
        end else if (!abort && w_mismatch) begin
            r_fail_mask <= r_fail_mask | w_diff;
            if (r_fail_count != CNT_MAX) begin
                r_fail_count <= r_fail_count + FAIL_CNT_W'(1);
            end
            if (!r_first_valid) begin
                r_first_vec   <= w_cmp_vec;
                r_first_valid <= 1'b1;
            end
        end
    end

    assign fail_mask        = r_fail_mask;
    assign fail_count       = r_fail_count;
    assign first_fail_vec   = r_first_vec;
    assign first_fail_valid = r_first_valid;

endmodule
